muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DIV0_LO, default 32'hFFFF_FFFF, the Lo value written on any divide by zero.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port Start, input, 1 bit: operation request, sampled on clk rising edge.
REQ-005 SHALL have port MdOp, input, 2 bits: operation; 00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
REQ-006 SHALL have port DataIn1, input, 32 bits: multiplicand or dividend (rs).
REQ-007 SHALL have port DataIn2, input, 32 bits: multiplier or divisor (rt).
REQ-008 SHALL have port HiWe, input, 1 bit: MTHI write enable; data on DataIn1.
REQ-009 SHALL have port LoWe, input, 1 bit: MTLO write enable; data on DataIn1.
REQ-010 SHALL have port Flush, input, 1 bit: abort the in-flight operation.
REQ-011 SHALL have port Busy, output, 1 bit: high while an operation is computing.
REQ-012 SHALL have port Done, output, 1 bit: one-cycle pulse after Hi/Lo update.
REQ-013 SHALL have port Hi, output, 32 bits: HI register.
REQ-014 SHALL have port Lo, output, 32 bits: LO register.

Function
REQ-015 SHALL implement FSM with states IDLE, CALC, DONE; Busy=(state==CALC); Done=(state==DONE); both registered-state decodes.
REQ-016 SHALL accept Start in IDLE or DONE: latch operands and MdOp, clear 5-bit iteration counter, go to CALC.
REQ-017 SHALL ignore Start while in CALC (no queuing, no restart).
REQ-018 SHALL perform one iteration per CALC cycle: shift-add multiply or restoring divide, on operand magnitudes for signed ops.
REQ-019 SHALL, on the edge where the counter equals 31, write Hi/Lo and go to DONE; acceptance at edge E0 gives Busy high E0..E32, Hi/Lo valid and Done high E32..E33.
REQ-020 SHALL go DONE -> IDLE next edge unless Start accepted (DONE -> CALC).
REQ-021 SHALL, for multiply, write Hi=product[63:32] and Lo=product[31:0]; MULT is signed 64-bit two's complement, MULTU unsigned.
REQ-022 SHALL, for divide, write Lo=quotient and Hi=remainder; DIV truncates toward zero with remainder sign equal to dividend sign; DIVU unsigned.
REQ-023 SHALL, for DIV of 32'h8000_0000 by 32'hFFFF_FFFF, write Lo=32'h8000_0000 and Hi=0.
REQ-024 SHALL, on divisor zero (DIV or DIVU), write Lo=DIV0_LO and Hi=dividend, with normal 32-cycle latency.
REQ-025 SHALL, with HiWe/LoWe in IDLE or DONE, load Hi/Lo from DataIn1 on that edge; with Start on the same edge, Start wins and the MT write is dropped.
REQ-026 SHALL ignore HiWe/LoWe in CALC.
REQ-027 SHALL, on Flush in CALC, go to IDLE next edge with Hi/Lo unchanged and no Done; Flush outside CALC has no effect; Flush beats Start on the same edge.
REQ-028 SHALL keep Hi/Lo stable at all times except the REQ-019 write, MT writes and reset.

Reset
REQ-029 SHALL, while rst=0, force immediately (no clock) state=IDLE, counter=0, Busy=0, Done=0, Hi=0, Lo=0, operand/work registers=0.
REQ-030 SHALL, on rst assertion mid-CALC, discard the operation; after release Start is accepted on the first clk edge.

Verification
REQ-031 SHALL pass: MULT 32'hFFFF_FFFD x 32'h0000_0005 -> Busy 32 cycles, then Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFF1, Done one cycle.
REQ-032 SHALL pass: MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> Hi=32'hFFFF_FFFE, Lo=32'h0000_0001.
REQ-033 SHALL pass: DIV 32'hFFFF_FFF9 (-7) / 2 -> Lo=32'hFFFF_FFFD, Hi=32'hFFFF_FFFF; DIV 8000_0000/FFFF_FFFF -> Lo=8000_0000, Hi=0.
REQ-034 SHALL pass: DIVU 100 / 0 -> Lo=32'hFFFF_FFFF, Hi=32'h0000_0064 after 32 cycles.
REQ-035 SHALL pass: Start pulsed again at cycle 10 of CALC, HiWe during CALC -> both ignored; first result still at E32.
REQ-036 SHALL pass: rst low at cycle 15 of CALC -> Busy=0, Hi=Lo=0 immediately; Flush at cycle 15 -> IDLE, Hi/Lo keep prior values, no Done.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle iterative multiply/divide unit with HI/LO registers
module muldiv_unit #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [1:0]  MdOp,
  input  logic [31:0] DataIn1,
  input  logic [31:0] DataIn2,
  input  logic        HiWe,
  input  logic        LoWe,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0] cnt;
  logic op_div, neg_q, neg_r;
  logic [31:0] hr, lr, opb;
  logic accept, fin, sgn;
  logic [32:0] msum;
  logic [33:0] ddiff;
  logic [31:0] nh, nl, qv, rv;
  logic [63:0] prod, sprod;
  assign Busy = state == CALC;
  assign Done = state == DONE;
  assign accept = Start && state != CALC;
  assign fin = state == CALC && !Flush && cnt == 5'd31;
  assign sgn = !MdOp[0];
  // hr/lr hold {acc, multiplier} for multiply and {remainder, dividend} for divide
  assign msum = {1'b0, hr} + {1'b0, lr[0] ? opb : 32'd0};
  assign ddiff = {1'b0, hr, lr[31]} - {2'b0, opb};
  assign nh = op_div ? (ddiff[33] ? {hr[30:0], lr[31]} : ddiff[31:0]) : msum[32:1];
  assign nl = op_div ? {lr[30:0], ~ddiff[33]} : {msum[0], lr[31:1]};
  assign prod = {nh, nl};
  assign sprod = neg_q ? -prod : prod;
  assign qv = opb == 32'd0 ? DIV0_LO : (neg_q ? -nl : nl);
  assign rv = neg_r ? -nh : nh;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // next state: Flush only acts in CALC, where Start is ignored
  always_comb begin
    state_nxt = state;
    if (state == CALC) state_nxt = Flush ? IDLE : (cnt == 5'd31 ? DONE : CALC);
    else state_nxt = Start ? CALC : IDLE;
  end
  // operand latch, iteration datapath and HI/LO update
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 5'd0;
      op_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hr <= 32'd0;
      lr <= 32'd0;
      opb <= 32'd0;
      Hi <= 32'd0;
      Lo <= 32'd0;
    end else begin
      if (accept) begin
        cnt <= 5'd0;
        op_div <= MdOp[1];
        neg_q <= sgn && (DataIn1[31] ^ DataIn2[31]);
        neg_r <= sgn && DataIn1[31];
        hr <= 32'd0;
        lr <= (sgn && DataIn1[31]) ? -DataIn1 : DataIn1;
        opb <= (sgn && DataIn2[31]) ? -DataIn2 : DataIn2;
      end else if (state == CALC) begin
        cnt <= cnt + 5'd1;
        hr <= nh;
        lr <= nl;
      end
      if (fin) begin
        Hi <= op_div ? rv : sprod[63:32];
        Lo <= op_div ? qv : sprod[31:0];
      end else if (state != CALC && !Start) begin
        if (HiWe) Hi <= DataIn1;
        if (LoWe) Lo <= DataIn1;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Start = 1'b0;
  logic [1:0] MdOp = 2'b00;
  logic [31:0] DataIn1 = 32'd0;
  logic [31:0] DataIn2 = 32'd0;
  logic HiWe = 1'b0;
  logic LoWe = 1'b0;
  logic Flush = 1'b0;
  logic Busy, Done;
  logic [31:0] Hi, Lo;
  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .Start(Start), .MdOp(MdOp),
    .DataIn1(DataIn1), .DataIn2(DataIn2), .HiWe(HiWe), .LoWe(LoWe),
    .Flush(Flush), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    Start = 1'b1; MdOp = op; DataIn1 = a; DataIn2 = b;
    step(1);
    Start = 1'b0;
    chk({tag, "_busy0"}, Busy, 1);
    step(31);
    chk({tag, "_busy31"}, Busy, 1);
    chk({tag, "_nodone31"}, Done, 0);
    step(1);
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_idlebusy"}, Busy, 0);
    chk({tag, "_hi"}, Hi, eh);
    chk({tag, "_lo"}, Lo, el);
    step(1);
    chk({tag, "_donedrop"}, Done, 0);
  endtask

  initial begin
    #3;
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    step(2);
    rst = 1'b1;
    step(1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, "divu_zero");
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
    run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7_m3");
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100_7");
    // MT writes in IDLE
    HiWe = 1'b1; DataIn1 = 32'h1234_5678;
    step(1);
    HiWe = 1'b0;
    chk("mthi_hi", Hi, 32'h1234_5678);
    chk("mthi_lo", Lo, 32'h0000_000E);
    LoWe = 1'b1; DataIn1 = 32'h9ABC_DEF0;
    step(1);
    LoWe = 1'b0;
    chk("mtlo_lo", Lo, 32'h9ABC_DEF0);
    // Start and MT on the same edge: Start wins
    Start = 1'b1; MdOp = 2'b01; DataIn1 = 32'd2; DataIn2 = 32'd3; HiWe = 1'b1; LoWe = 1'b1;
    step(1);
    Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
    chk("stmt_busy", Busy, 1);
    chk("stmt_hi", Hi, 32'h1234_5678);
    chk("stmt_lo", Lo, 32'h9ABC_DEF0);
    step(32);
    chk("stmt_done", Done, 1);
    chk("stmt_rhi", Hi, 32'd0);
    chk("stmt_rlo", Lo, 32'd6);
    // MT in DONE, then Start/HiWe during CALC ignored
    HiWe = 1'b1; LoWe = 1'b1; DataIn1 = 32'h0000_5555;
    step(1);
    HiWe = 1'b0; LoWe = 1'b0;
    chk("mt_both_hi", Hi, 32'h0000_5555);
    chk("mt_both_lo", Lo, 32'h0000_5555);
    Start = 1'b1; MdOp = 2'b01; DataIn1 = 32'd3; DataIn2 = 32'd4;
    step(1);
    Start = 1'b0;
    step(9);
    Start = 1'b1; MdOp = 2'b11; DataIn1 = 32'h0000_DEAD; DataIn2 = 32'd1; HiWe = 1'b1;
    step(1);
    Start = 1'b0; HiWe = 1'b0;
    chk("ign_hi", Hi, 32'h0000_5555);
    chk("ign_busy", Busy, 1);
    step(21);
    chk("ign_busy31", Busy, 1);
    chk("ign_nodone", Done, 0);
    step(1);
    chk("ign_done", Done, 1);
    chk("ign_rhi", Hi, 32'd0);
    chk("ign_rlo", Lo, 32'd12);
    // Start while in DONE goes straight back to CALC
    Start = 1'b1; MdOp = 2'b01; DataIn1 = 32'd6; DataIn2 = 32'd7;
    step(1);
    Start = 1'b0;
    chk("d2c_busy", Busy, 1);
    chk("d2c_done", Done, 0);
    step(31);
    chk("d2c_nodone", Done, 0);
    step(1);
    chk("d2c_fin", Done, 1);
    chk("d2c_lo", Lo, 32'd42);
    // Flush at cycle 15
    Start = 1'b1; MdOp = 2'b00; DataIn1 = 32'hFFFF_FFFF; DataIn2 = 32'd2;
    step(1);
    Start = 1'b0;
    step(14);
    Flush = 1'b1;
    step(1);
    Flush = 1'b0;
    chk("fl_busy", Busy, 0);
    chk("fl_done", Done, 0);
    chk("fl_hi", Hi, 32'd0);
    chk("fl_lo", Lo, 32'd42);
    step(20);
    chk("fl_late_done", Done, 0);
    chk("fl_late_lo", Lo, 32'd42);
    // Async reset at cycle 15
    Start = 1'b1; MdOp = 2'b01; DataIn1 = 32'd5; DataIn2 = 32'd5;
    step(1);
    Start = 1'b0;
    step(14);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", Busy, 0);
    chk("ar_done", Done, 0);
    chk("ar_hi", Hi, 32'd0);
    chk("ar_lo", Lo, 32'd0);
    step(1);
    rst = 1'b1;
    run_op(2'b01, 32'd10, 32'd10, 32'd0, 32'd100, "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
